// File: rtl/wb_frame_dma.sv
// Wishbone initiator for the sobel accelerator: streams a frame in, starts the
// core, waits for done, then reads the result frame back out to a sink stream.
module wb_frame_dma #(
    parameter int                ADDR_W  = 22,
    parameter int                DATA_W  = 32,
    parameter logic [ADDR_W-1:0] WR_LAST = 22'h4B000,
    parameter logic [ADDR_W-1:0] RD_LAST = 22'h4AB00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              snk_valid,
    output logic [DATA_W-1:0] snk_data,
    input  logic              snk_ready,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic [DATA_W-1:0] dat_o,
    input  logic [DATA_W-1:0] dat_i,
    input  logic              ack_i,
    output logic              start_o,
    input  logic              done_i,
    output logic              busy,
    output logic              finished
);

    typedef enum logic [2:0] {
        IDLE,
        WR_FETCH,
        WR_WAIT,
        RUN,
        RD_REQ,
        RD_WAIT,
        RD_PUSH,
        FIN
    } state_t;

    state_t state_reg;

    localparam logic [ADDR_W-1:0] ADR_STEP = ADDR_W'(4);

    // Decoded from state so they drop together with the asynchronous reset.
    assign src_ready = (state_reg == WR_FETCH);
    assign busy      = (state_reg != IDLE);
    assign finished  = (state_reg == FIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            adr_o     <= '0;
            dat_o     <= '0;
            start_o   <= 1'b0;
            snk_valid <= 1'b0;
            snk_data  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (go) begin
                        we_o      <= 1'b1;
                        cyc_o     <= 1'b1;
                        state_reg <= WR_FETCH;
                    end
                end
                WR_FETCH: begin
                    if (src_valid) begin
                        dat_o     <= src_data;
                        stb_o     <= 1'b1;
                        state_reg <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (ack_i) begin
                        stb_o <= 1'b0;
                        if (adr_o == WR_LAST) begin
                            cyc_o     <= 1'b0;
                            adr_o     <= '0;
                            start_o   <= 1'b1;
                            state_reg <= RUN;
                        end else begin
                            adr_o     <= adr_o + ADR_STEP;
                            state_reg <= WR_FETCH;
                        end
                    end
                end
                RUN: begin
                    if (done_i) begin
                        start_o   <= 1'b0;
                        we_o      <= 1'b0;
                        adr_o     <= '0;
                        state_reg <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    cyc_o     <= 1'b1;
                    stb_o     <= 1'b1;
                    state_reg <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (ack_i) begin
                        snk_data  <= dat_i;
                        snk_valid <= 1'b1;
                        stb_o     <= 1'b0;
                        state_reg <= RD_PUSH;
                    end
                end
                RD_PUSH: begin
                    if (snk_ready) begin
                        snk_valid <= 1'b0;
                        if (adr_o == RD_LAST) begin
                            cyc_o     <= 1'b0;
                            state_reg <= FIN;
                        end else begin
                            adr_o     <= adr_o + ADR_STEP;
                            state_reg <= RD_REQ;
                        end
                    end
                end
                FIN: begin
                    // Leave the write-data bus clean so IDLE presents all zeros.
                    dat_o     <= '0;
                    adr_o     <= '0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_frame_dma.sv
// Directed bench for wb_frame_dma on a small 4-write / 3-read frame with a
// simple Wishbone slave whose ack latency and stream back-pressure vary.
module tb_wb_frame_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic        src_valid = 1'b0;
    logic [31:0] src_data = '0;
    logic        src_ready;
    logic        snk_valid;
    logic [31:0] snk_data;
    logic        snk_ready = 1'b0;
    logic        cyc_o, stb_o, we_o;
    logic [21:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        start_o;
    logic        done_i = 1'b0;
    logic        busy, finished;

    int tests = 0;
    int fails = 0;

    wb_frame_dma #(
        .ADDR_W (22),
        .DATA_W (32),
        .WR_LAST(22'd12),
        .RD_LAST(22'd8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .src_valid(src_valid),
        .src_data (src_data),
        .src_ready(src_ready),
        .snk_valid(snk_valid),
        .snk_data (snk_data),
        .snk_ready(snk_ready),
        .cyc_o    (cyc_o),
        .stb_o    (stb_o),
        .we_o     (we_o),
        .adr_o    (adr_o),
        .dat_o    (dat_o),
        .dat_i    (dat_i),
        .ack_i    (ack_i),
        .start_o  (start_o),
        .done_i   (done_i),
        .busy     (busy),
        .finished (finished)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slave: acks after ack_delay extra cycles of strobe; reads return tagged address.
    int          ack_delay = 0;
    logic [3:0]  wait_cnt;
    assign ack_i = cyc_o && stb_o && (wait_cnt == 4'(ack_delay));
    assign dat_i = 32'hC0DE_0000 | {10'd0, adr_o};

    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= '0;
        else if (cyc_o && stb_o && !ack_i) wait_cnt <= wait_cnt + 4'd1;
        else wait_cnt <= '0;
    end

    logic [31:0] wr_adr_q[$];
    logic [31:0] wr_dat_q[$];
    int          fin_cnt = 0;
    logic        pend_reg = 1'b0;
    logic [21:0] pend_adr;
    logic [31:0] pend_dat;

    // Bus monitor: logs acked writes, counts finished pulses, checks holds.
    always @(negedge clk) begin
        if (!rst) begin
            if (cyc_o && stb_o && we_o && ack_i) begin
                wr_adr_q.push_back({10'd0, adr_o});
                wr_dat_q.push_back(dat_o);
            end
            if (finished) fin_cnt++;
            if (stb_o) check_eq("stb_needs_cyc", {31'd0, cyc_o}, 32'd1);
            if (stb_o && pend_reg) begin
                check_eq("hold_adr", {10'd0, adr_o}, {10'd0, pend_adr});
                check_eq("hold_dat", dat_o, pend_dat);
            end
            pend_reg = stb_o && !ack_i;
            pend_adr = adr_o;
            pend_dat = dat_o;
        end else begin
            pend_reg = 1'b0;
        end
    end

    logic [31:0] wexp[4];
    logic [31:0] rexp[3];

    task automatic check_all_zero(input string tag);
        logic [31:0] agg;
        agg = {22'd0, cyc_o, stb_o, we_o, start_o, snk_valid, src_ready, busy, finished, 2'b00};
        check_eq({tag, "_ctl"}, agg, 32'd0);
        check_eq({tag, "_adr"}, {10'd0, adr_o}, 32'd0);
        check_eq({tag, "_dat"}, dat_o, 32'd0);
        check_eq({tag, "_snk"}, snk_data, 32'd0);
    endtask

    task automatic pulse_go();
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
        check_eq("go_busy", {31'd0, busy}, 32'd1);
        check_eq("go_cyc", {31'd0, cyc_o}, 32'd1);
        check_eq("go_we", {31'd0, we_o}, 32'd1);
        check_eq("go_src_ready", {31'd0, src_ready}, 32'd1);
    endtask

    task automatic run_frame(input int ad, input bit tog, input int stall, input bit spur);
        int fin0;
        ack_delay = ad;
        wr_adr_q.delete();
        wr_dat_q.delete();
        fin0 = fin_cnt;
        pulse_go();
        fork
            begin : source
                int sent = 0;
                int n = 0;
                while (sent < 4 && n < 300) begin
                    @(negedge clk);
                    n++;
                    src_valid = tog ? n[0] : 1'b1;
                    src_data  = wexp[sent];
                    if (spur && sent == 2) begin
                        done_i = 1'b1;
                        go     = 1'b1;
                    end else begin
                        done_i = 1'b0;
                        go     = 1'b0;
                    end
                    if (src_valid && src_ready) sent++;
                end
                check_eq("src_words", sent, 4);
                @(negedge clk);
                src_valid = 1'b0;
                done_i    = 1'b0;
                go        = 1'b0;
            end
            begin : accel
                int n = 0;
                while (!start_o && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                check_eq("start_seen", {31'd0, start_o}, 32'd1);
                check_eq("start_after_wr", wr_adr_q.size(), 4);
                check_eq("run_cyc_low", {31'd0, cyc_o}, 32'd0);
                repeat (4) @(negedge clk);
                check_eq("start_held", {31'd0, start_o}, 32'd1);
                done_i = 1'b1;
                @(negedge clk);
                done_i = 1'b0;
                check_eq("start_fall", {31'd0, start_o}, 32'd0);
            end
            begin : sink
                int r = 0;
                int st = 0;
                int n = 0;
                while (r < 3 && n < 600) begin
                    @(negedge clk);
                    n++;
                    snk_ready = (st >= stall);
                    if (snk_valid) begin
                        check_eq("snk_data", snk_data, rexp[r]);
                        if (snk_ready) begin
                            r++;
                            st = 0;
                        end else begin
                            st++;
                        end
                    end
                end
                check_eq("snk_words", r, 3);
                @(negedge clk);
                snk_ready = 1'b0;
                check_eq("fin_pulse", {31'd0, finished}, 32'd1);
                @(negedge clk);
                check_eq("busy_fall", {31'd0, busy}, 32'd0);
                check_eq("fin_low", {31'd0, finished}, 32'd0);
            end
        join
        check_eq("wr_count", wr_adr_q.size(), 4);
        for (int i = 0; i < wr_adr_q.size() && i < 4; i++) begin
            check_eq("wr_adr", wr_adr_q[i], 32'(i * 4));
            check_eq("wr_dat", wr_dat_q[i], wexp[i]);
        end
        check_eq("fin_once", fin_cnt - fin0, 1);
        $display("[TB] frame ack_delay=%0d toggle=%0d stall=%0d spurious=%0d done", ad, tog, stall, spur);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wexp[0] = 32'h11; wexp[1] = 32'h22; wexp[2] = 32'h33; wexp[3] = 32'h44;
        rexp[0] = 32'hC0DE_0000; rexp[1] = 32'hC0DE_0004; rexp[2] = 32'hC0DE_0008;

        #1;
        check_all_zero("reset");
        @(negedge clk) rst = 1'b0;

        run_frame(0, 1'b0, 0, 1'b0);
        run_frame(3, 1'b0, 0, 1'b0);
        run_frame(0, 1'b1, 5, 1'b0);
        run_frame(1, 1'b0, 1, 1'b1);

        // Reset in the middle of the write phase.
        ack_delay = 0;
        pulse_go();
        begin
            int sent = 0;
            int n = 0;
            while (sent < 2 && n < 100) begin
                @(negedge clk);
                n++;
                src_valid = 1'b1;
                src_data  = wexp[sent];
                if (src_ready) sent++;
            end
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("mid_reset");
        @(negedge clk);
        src_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        run_frame(0, 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
